// File: rtl/octal_digit_serializer_if.sv
// Handshake bundle between the binary word producer, the octal serializer
// and the digit consumer.
interface octal_digit_serializer_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_digit;
  logic             out_first;
  logic             out_last;
  logic             busy;

  // The serializer itself: takes words in and drives digits out.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_digit, out_first, out_last, busy
  );

  // The surrounding logic: offers words and consumes digits.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_digit, out_first, out_last, busy
  );
endinterface

// File: rtl/octal_digit_serializer.sv
// Captures a binary word and emits its octal digits MSD first, one per
// accepted beat, optionally skipping leading zero digits.
module octal_digit_serializer #(
  parameter int WIDTH       = 12,
  parameter bit SUPPRESS_LZ = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  octal_digit_serializer_if.slave   bus
);

  localparam int NDIG = (WIDTH + 2) / 3;
  localparam int PW   = 3 * NDIG;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          first_q, first_d;

  logic [PW-1:0] padded;
  logic [IW-1:0] start_idx;
  logic [2:0]    cur_digit;
  logic          at_last;

  assign padded  = PW'(bus.in_data);
  assign at_last = (idx_q == '0);

  // Start digit: the highest nonzero digit when suppressing, else the top one.
  always_comb begin
    start_idx = IW'(NDIG - 1);
    if (SUPPRESS_LZ) begin
      start_idx = '0;
      for (int i = 0; i < NDIG; i++) begin
        if (padded[3*i +: 3] != 3'd0) start_idx = IW'(i);
      end
    end
  end

  always_comb begin
    cur_digit = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) cur_digit = word_q[3*i +: 3];
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          word_d  = padded;
          idx_d   = start_idx;
          first_d = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (bus.out_ready) begin
          first_d = 1'b0;
          if (at_last) begin
            word_d  = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      first_q <= first_d;
    end
  end

  // Outputs depend only on flops, so they hold steady under backpressure.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == EMIT);
  assign bus.busy      = (state_q == EMIT);
  assign bus.out_digit = (state_q == EMIT) ? cur_digit : 3'd0;
  assign bus.out_first = (state_q == EMIT) && first_q;
  assign bus.out_last  = (state_q == EMIT) && at_last;

endmodule

// File: tb/tb_octal_digit_serializer.sv
// Directed bench for octal_digit_serializer: three instances cover leading
// zero suppression on/off and a non-multiple-of-3 width.
module tb_octal_digit_serializer;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  octal_digit_serializer_if #(.WIDTH(12)) b1 ();
  octal_digit_serializer_if #(.WIDTH(12)) b0 ();
  octal_digit_serializer_if #(.WIDTH(8))  b8 ();

  octal_digit_serializer #(.WIDTH(12), .SUPPRESS_LZ(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  octal_digit_serializer #(.WIDTH(12), .SUPPRESS_LZ(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  octal_digit_serializer #(.WIDTH(8),  .SUPPRESS_LZ(1'b0)) u8 (.clk(clk), .reset(reset), .bus(b8));

  // {out_valid, out_digit, out_first, out_last, busy, in_ready}
  logic [7:0] obs1, obs0, obs8;
  assign obs1 = {b1.out_valid, b1.out_digit, b1.out_first, b1.out_last, b1.busy, b1.in_ready};
  assign obs0 = {b0.out_valid, b0.out_digit, b0.out_first, b0.out_last, b0.busy, b0.in_ready};
  assign obs8 = {b8.out_valid, b8.out_digit, b8.out_first, b8.out_last, b8.busy, b8.in_ready};

  localparam logic [7:0] IDLE_OBS = 8'b0_000_0_0_0_1;

  // Offers one word at the current negedge; the word is captured at the next posedge.
  task automatic send(input int which, input logic [11:0] data);
    int   guard = 0;
    logic rdy;
    rdy = (which == 1) ? b1.in_ready : (which == 0) ? b0.in_ready : b8.in_ready;
    while (!rdy && guard < 50) begin
      @(negedge clk);
      guard++;
      rdy = (which == 1) ? b1.in_ready : (which == 0) ? b0.in_ready : b8.in_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: in_ready got %b expected 1", rdy);
    end
    case (which)
      1:       begin b1.in_valid = 1'b1; b1.in_data = data; end
      0:       begin b0.in_valid = 1'b1; b0.in_data = data; end
      default: begin b8.in_valid = 1'b1; b8.in_data = data[7:0]; end
    endcase
    @(negedge clk);
    b1.in_valid = 1'b0;
    b0.in_valid = 1'b0;
    b8.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL reset_u1: got %b expected %b", obs1, IDLE_OBS); end
    checks++;
    if (obs0 !== IDLE_OBS) begin errors++; $display("[TB] FAIL reset_u0: got %b expected %b", obs0, IDLE_OBS); end
    checks++;
    if (obs8 !== IDLE_OBS) begin errors++; $display("[TB] FAIL reset_u8: got %b expected %b", obs8, IDLE_OBS); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL post_reset_idle: got %b expected %b", obs1, IDLE_OBS); end
  endtask

  task automatic test_basic();
    logic [2:0] d [4];
    logic [7:0] exp;
    d = '{3'd7, 3'd5, 3'd3, 3'd1};
    send(1, 12'hF59);
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, d[i], (i == 0), (i == 3), 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL basic_digit%0d: got %b expected %b", i, obs1, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL basic_idle: got %b expected %b", obs1, IDLE_OBS); end
  endtask

  task automatic test_suppress();
    logic [2:0] d [4];
    logic [7:0] exp;
    send(1, 12'h009);
    for (int i = 0; i < 2; i++) begin
      exp = {1'b1, 3'd1, (i == 0), (i == 1), 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL lz_on_digit%0d: got %b expected %b", i, obs1, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL lz_on_idle: got %b expected %b", obs1, IDLE_OBS); end

    send(1, 12'h000);
    exp = {1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL zero_word: got %b expected %b", obs1, exp); end
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL zero_idle: got %b expected %b", obs1, IDLE_OBS); end

    d = '{3'd0, 3'd0, 3'd1, 3'd1};
    send(0, 12'h009);
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, d[i], (i == 0), (i == 3), 1'b1, 1'b0};
      checks++;
      if (obs0 !== exp) begin errors++; $display("[TB] FAIL lz_off_digit%0d: got %b expected %b", i, obs0, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs0 !== IDLE_OBS) begin errors++; $display("[TB] FAIL lz_off_idle: got %b expected %b", obs0, IDLE_OBS); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    send(1, 12'hF59);
    exp = {1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL bp_digit7: got %b expected %b", obs1, exp); end
    @(negedge clk);
    b1.out_ready = 1'b0;
    exp = {1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL bp_hold%0d: got %b expected %b", i, obs1, exp); end
      if (i < 3) @(negedge clk);
    end
    b1.out_ready = 1'b1;
    @(negedge clk);
    exp = {1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL bp_digit3: got %b expected %b", obs1, exp); end
    @(negedge clk);
    exp = {1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL bp_digit1: got %b expected %b", obs1, exp); end
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL bp_idle: got %b expected %b", obs1, IDLE_OBS); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] d [4];
    logic [7:0] exp;
    d = '{3'd7, 3'd5, 3'd3, 3'd1};
    send(1, 12'hF59);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) begin
        b1.in_valid = 1'b1;
        b1.in_data  = 12'h123;
      end else begin
        b1.in_valid = 1'b0;
      end
      exp = {1'b1, d[i], (i == 0), (i == 3), 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL ignore_digit%0d: got %b expected %b", i, obs1, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL ignore_idle: got %b expected %b", obs1, IDLE_OBS); end
    // 12'h924 = 2340 = octal 4444
    send(1, 12'h924);
    for (int i = 0; i < 4; i++) begin
      exp = {1'b1, 3'd4, (i == 0), (i == 3), 1'b1, 1'b0};
      checks++;
      if (obs1 !== exp) begin errors++; $display("[TB] FAIL b2b_digit%0d: got %b expected %b", i, obs1, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL b2b_idle: got %b expected %b", obs1, IDLE_OBS); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp;
    send(1, 12'hF59);
    @(negedge clk);
    @(negedge clk);
    exp = {1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL mid_pre_reset: got %b expected %b", obs1, exp); end
    reset = 1'b1;
    #1;
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL mid_async_reset: got %b expected %b", obs1, IDLE_OBS); end
    #2;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL mid_after_release: got %b expected %b", obs1, IDLE_OBS); end
    send(1, 12'h001);
    exp = {1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs1 !== exp) begin errors++; $display("[TB] FAIL mid_new_word: got %b expected %b", obs1, exp); end
    @(negedge clk);
    checks++;
    if (obs1 !== IDLE_OBS) begin errors++; $display("[TB] FAIL mid_final_idle: got %b expected %b", obs1, IDLE_OBS); end
  endtask

  task automatic test_width8();
    logic [2:0] d [3];
    logic [7:0] exp;
    d = '{3'd3, 3'd7, 3'd7};
    send(8, 12'h0FF);
    for (int i = 0; i < 3; i++) begin
      exp = {1'b1, d[i], (i == 0), (i == 2), 1'b1, 1'b0};
      checks++;
      if (obs8 !== exp) begin errors++; $display("[TB] FAIL w8_digit%0d: got %b expected %b", i, obs8, exp); end
      @(negedge clk);
    end
    checks++;
    if (obs8 !== IDLE_OBS) begin errors++; $display("[TB] FAIL w8_idle: got %b expected %b", obs8, IDLE_OBS); end
  endtask

  initial begin
    reset        = 1'b1;
    b1.in_valid  = 1'b0; b1.in_data = '0; b1.out_ready = 1'b1;
    b0.in_valid  = 1'b0; b0.in_data = '0; b0.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.in_data = '0; b8.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_suppress();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time got 200000 expected under 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
